l2_port_arbiter: RTL
====================

L2_PORT_ARBITER -- requirements
Module: l2_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, word-address width of the L2 SRAM port (depth 2^ADDR_WIDTH words).
REQ-002 Parameter MAX_WAIT, default 8, cycles master 1 may be denied in priority mode before forced grant (range 1..255).
REQ-003 Port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port prio_mode_i  input  1  0 = round-robin, 1 = master 0 (JTAG debug) fixed priority with starvation guard.
REQ-006 Ports mK_req_i input 1, mK_we_i input 1, mK_be_i input 4, mK_addr_i input 32 (byte address), mK_wdata_i input 32; K = 0 (JTAG debug bridge), 1 (system master).
REQ-007 Ports mK_gnt_o output 1, mK_rvalid_o output 1, mK_rdata_o output 32, mK_err_o output 1; K = 0, 1.
REQ-008 Ports mem_req_o output 1, mem_we_o output 1, mem_be_o output 4, mem_addr_o output ADDR_WIDTH, mem_wdata_o output 32, mem_rdata_i input 32 (valid exactly 1 cycle after a read request).

Function
REQ-009 Grant is combinational in the request cycle: at most one mK_gnt_o high per cycle; a request is accepted when mK_req_i and mK_gnt_o are both high.
REQ-010 Master holds req, we, be, addr, wdata stable until granted; the block shall not grant a master whose req is low.
REQ-011 Round-robin: single requester always granted; both requesting -> grant the master not granted most recently (last_grant register updated on each accepted request).
REQ-012 Priority mode: master 0 wins conflicts; starve counter increments each cycle master 1 requests and is not granted, clears when master 1 is granted or drops req.
REQ-013 Priority mode: when starve counter equals MAX_WAIT, master 1 wins the next conflict; counter saturates, never wraps.
REQ-014 prio_mode_i changes take effect the same cycle; starve counter clears when prio_mode_i is 0.
REQ-015 In-range access: addr[31:ADDR_WIDTH+2] all zero; mem_addr_o = addr[ADDR_WIDTH+1:2]; addr[1:0] ignored.
REQ-016 Accepted in-range access drives mem_req_o=1 with we, be, wdata of the granted master the same cycle; mem outputs zero when nothing is accepted.
REQ-017 Out-of-range access: granted, mem_req_o stays 0, response flagged as error.
REQ-018 Response pipeline: one register stage {valid, owner, err, we}; every accepted request yields exactly one mK_rvalid_o pulse to its owner exactly 1 cycle later, reads and writes alike.
REQ-019 Response data: read in-range -> mK_rdata_o = mem_rdata_i; error -> 32'hBADACCE5 and mK_err_o=1; write -> rdata 0, err 0.
REQ-020 Non-owner master sees rvalid 0, rdata 0, err 0 in a response cycle.
REQ-021 Back-to-back: a new request is accepted in the same cycle a previous response is returned; full throughput of 1 access/cycle.
REQ-022 No combinational path from mem_rdata_i to any grant or mem_* output.

Reset
REQ-023 While rst_n low: all gnt, rvalid, err, rdata outputs and all mem_* outputs 0; last_grant = 1 (master 0 favoured first); starve counter 0; response stage invalid.
REQ-024 Reset asserted with a response pending discards it; no rvalid pulse appears after rst_n rises.
REQ-025 First cycle after rst_n rises the block is fully operational.

Verification
REQ-026 M0 write addr 0x0000_0000 data 0xABBAABBA be 0xF, then read 0x0 -> mem write word 0, m0_rvalid_o pulse 1 cycle after each grant, read returns 0xABBAABBA, err 0.
REQ-027 Round-robin, both masters request continuously for 6 cycles -> grants alternate M0,M1,M0,M1,M0,M1; each rvalid to correct owner 1 cycle later.
REQ-028 prio_mode_i=1, MAX_WAIT=8, both request continuously -> M0 granted 8 consecutive cycles, M1 granted on the 9th, counter cleared, M0 resumes.
REQ-029 M1 read at 0x0001_0000 with ADDR_WIDTH=14 -> granted, mem_req_o 0, next cycle m1_rvalid_o=1, m1_err_o=1, m1_rdata_o=0xBADACCE5.
REQ-030 M1 read granted, rst_n pulsed low the following cycle -> no m1_rvalid_o ever, all outputs 0 during reset, next access after release served normally with M0 winning the first conflict.
REQ-031 Byte-enable write be=0x3 data 0x1234_5678 to word 5 -> mem_be_o=0x3, mem_addr_o=5, mem_wdata_o=0x1234_5678 in grant cycle.

Source files
------------

// File: rtl/l2_port_arbiter_if.sv
// Bus bundle for the two-master L2 SRAM port arbiter.
// slave  : arbiter side (takes both master request buses, drives the SRAM port)
// master : requester side (JTAG debug bridge = m0, system master = m1)
// mem    : SRAM side
interface l2_port_arbiter_if #(
   parameter int ADDR_WIDTH = 14
);
   logic                  m0_req_i;
   logic                  m0_we_i;
   logic [3:0]            m0_be_i;
   logic [31:0]           m0_addr_i;
   logic [31:0]           m0_wdata_i;
   logic                  m0_gnt_o;
   logic                  m0_rvalid_o;
   logic [31:0]           m0_rdata_o;
   logic                  m0_err_o;

   logic                  m1_req_i;
   logic                  m1_we_i;
   logic [3:0]            m1_be_i;
   logic [31:0]           m1_addr_i;
   logic [31:0]           m1_wdata_i;
   logic                  m1_gnt_o;
   logic                  m1_rvalid_o;
   logic [31:0]           m1_rdata_o;
   logic                  m1_err_o;

   logic                  mem_req_o;
   logic                  mem_we_o;
   logic [3:0]            mem_be_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [31:0]           mem_wdata_o;
   logic [31:0]           mem_rdata_i;

   modport slave (
      input  m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
      output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
      input  m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
      output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i
   );

   modport master (
      output m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
      input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
      output m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
      input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o
   );

   modport mem (
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i
   );
endinterface

// File: rtl/l2_port_arbiter.sv
// Two-master arbiter in front of a single-port L2 SRAM.
// Master 0 is the JTAG debug bridge, master 1 the system master. Grants are
// combinational in the request cycle; every accepted access returns exactly one
// response one cycle later through a single register stage. Accesses above the
// SRAM window are granted but never reach the SRAM and return an error word.
module l2_port_arbiter #(
   parameter int ADDR_WIDTH = 14,
   parameter int MAX_WAIT   = 8
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic              prio_mode_i,
   l2_port_arbiter_if.slave  bus
);

   localparam logic [31:0] ERR_DATA   = 32'hBADACCE5;
   localparam logic [7:0]  MAX_WAIT_C = 8'(MAX_WAIT);

   // Arbitration state
   logic        r_last_grant;     // index of the master granted most recently
   logic [7:0]  r_starve_cnt;     // cycles master 1 has been denied in priority mode

   // Response stage
   logic        r_rsp_valid;
   logic        r_rsp_owner;
   logic        r_rsp_err;
   logic        r_rsp_we;

   logic        w_gnt0;
   logic        w_gnt1;
   logic        w_accept;
   logic        w_we;
   logic [3:0]  w_be;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;
   logic        w_in_range;
   logic        w_mem_req;
   logic [7:0]  w_starve_nxt;
   logic [31:0] w_rsp_data;

   // Grant decision: gated by reset, never grants an idle master
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (rst_n == 1'b0) begin
         w_gnt0 = 1'b0;
         w_gnt1 = 1'b0;
      end else if (bus.m0_req_i && bus.m1_req_i) begin
         if (prio_mode_i) begin
            // debug master wins unless master 1 has waited long enough
            if (r_starve_cnt == MAX_WAIT_C) begin
               w_gnt1 = 1'b1;
            end else begin
               w_gnt0 = 1'b1;
            end
         end else begin
            // round-robin: favour whichever master was not granted last
            if (r_last_grant) begin
               w_gnt0 = 1'b1;
            end else begin
               w_gnt1 = 1'b1;
            end
         end
      end else if (bus.m0_req_i) begin
         w_gnt0 = 1'b1;
      end else if (bus.m1_req_i) begin
         w_gnt1 = 1'b1;
      end else begin
         w_gnt0 = 1'b0;
         w_gnt1 = 1'b0;
      end
   end

   // Request mux towards the SRAM plus window decode
   always_comb begin
      w_accept = w_gnt0 | w_gnt1;
      if (w_gnt1) begin
         w_we    = bus.m1_we_i;
         w_be    = bus.m1_be_i;
         w_addr  = bus.m1_addr_i;
         w_wdata = bus.m1_wdata_i;
      end else begin
         w_we    = bus.m0_we_i;
         w_be    = bus.m0_be_i;
         w_addr  = bus.m0_addr_i;
         w_wdata = bus.m0_wdata_i;
      end
      // bits above the word index must be clear; addr[1:0] is a don't-care
      w_in_range = ((w_addr >> (ADDR_WIDTH + 2)) == 32'd0);
      w_mem_req  = w_accept & w_in_range;
   end

   // Starvation counter next value: saturating, cleared outside priority mode
   always_comb begin
      w_starve_nxt = r_starve_cnt;
      if (!prio_mode_i) begin
         w_starve_nxt = 8'd0;
      end else if (bus.m1_req_i && !w_gnt1) begin
         if (r_starve_cnt < MAX_WAIT_C) begin
            w_starve_nxt = r_starve_cnt + 8'd1;
         end else begin
            w_starve_nxt = r_starve_cnt;
         end
      end else begin
         w_starve_nxt = 8'd0;
      end
   end

   // Arbitration state and response stage registers
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= 1'b1;
         r_starve_cnt <= 8'd0;
         r_rsp_valid  <= 1'b0;
         r_rsp_owner  <= 1'b0;
         r_rsp_err    <= 1'b0;
         r_rsp_we     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_last_grant <= w_gnt1;
         end else begin
            r_last_grant <= r_last_grant;
         end
         r_starve_cnt <= w_starve_nxt;
         r_rsp_valid  <= w_accept;
         r_rsp_owner  <= w_gnt1;
         r_rsp_err    <= w_accept & ~w_in_range;
         r_rsp_we     <= w_accept & w_we;
      end
   end

   // Response word: error takes precedence, writes return zero
   always_comb begin
      w_rsp_data = 32'd0;
      if (r_rsp_err) begin
         w_rsp_data = ERR_DATA;
      end else if (r_rsp_we) begin
         w_rsp_data = 32'd0;
      end else begin
         w_rsp_data = bus.mem_rdata_i;
      end
   end

   assign bus.m0_gnt_o    = w_gnt0;
   assign bus.m1_gnt_o    = w_gnt1;

   assign bus.mem_req_o   = w_mem_req;
   assign bus.mem_we_o    = w_mem_req & w_we;
   assign bus.mem_be_o    = w_mem_req ? w_be : 4'h0;
   assign bus.mem_addr_o  = w_mem_req ? w_addr[ADDR_WIDTH+1:2] : {ADDR_WIDTH{1'b0}};
   assign bus.mem_wdata_o = w_mem_req ? w_wdata : 32'd0;

   assign bus.m0_rvalid_o = r_rsp_valid & ~r_rsp_owner;
   assign bus.m0_rdata_o  = (r_rsp_valid & ~r_rsp_owner) ? w_rsp_data : 32'd0;
   assign bus.m0_err_o    = r_rsp_valid & ~r_rsp_owner & r_rsp_err;
   assign bus.m1_rvalid_o = r_rsp_valid & r_rsp_owner;
   assign bus.m1_rdata_o  = (r_rsp_valid & r_rsp_owner) ? w_rsp_data : 32'd0;
   assign bus.m1_err_o    = r_rsp_valid & r_rsp_owner & r_rsp_err;

endmodule
